// File: rtl/mac_pkg.sv
// Shared constants and types for the mac8 multiply-accumulate datapath.
package mac_pkg;

    localparam int OP_W          = 8;
    localparam int PROD_W        = 16;
    localparam int CNT_W         = 8;
    localparam int CNT_MAX       = 255;
    localparam int ACC_W_DEFAULT = 24;

    typedef logic [OP_W-1:0]   op_t;
    typedef logic [PROD_W-1:0] prod_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    // Term counter step that sticks at the top value instead of wrapping.
    function automatic cnt_t cnt_sat_inc(input cnt_t c);
        return (c == cnt_t'(CNT_MAX)) ? c : c + cnt_t'(1);
    endfunction

endpackage

// File: rtl/multiply8.sv
// 8x8 unsigned combinational multiplier array. The clk pin exists for
// drop-in compatibility with pipelined variants and is not used here.
module multiply8
    import mac_pkg::*;
(
    input  logic  clk,
    input  op_t   a_i,
    input  op_t   b_i,
    output prod_t p_o
);

    logic unused_clk;
    assign unused_clk = clk;

    assign p_o = prod_t'(a_i) * prod_t'(b_i);

endmodule

// File: rtl/mac8_accumulator.sv
// Streaming MAC stage: operand register -> product register -> accumulator
// with a single registered result slot. One global stall freezes the whole
// pipe while a held result waits for the consumer.
module mac8_accumulator
    import mac_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [7:0]       out_count,
    output logic             out_ovf
);

    logic             en;
    prod_t            prod;
    logic [ACC_W:0]   sum;
    cnt_t             cnt_inc;
    logic             ovf_new;

    op_t              a_q, a_d, b_q, b_d;
    logic             v1_q, v1_d, l1_q, l1_d;
    prod_t            p_q, p_d;
    logic             v2_q, v2_d, l2_q, l2_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    cnt_t             cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [ACC_W-1:0] osum_q, osum_d;
    cnt_t             ocnt_q, ocnt_d;
    logic             oovf_q, oovf_d;
    logic             ovld_q, ovld_d;

    // Pipe advances unless a held result is blocked or a soft clear is active.
    assign en       = !(ovld_q && !out_ready) && !clr;
    assign in_ready = en;

    multiply8 u_mul (
        .clk (clk),
        .a_i (a_q),
        .b_i (b_q),
        .p_o (prod)
    );

    // One extra bit on the adder exposes the carry out of ACC_W for the sticky flag.
    assign sum     = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, p_q};
    assign cnt_inc = cnt_sat_inc(cnt_q);
    assign ovf_new = ovf_q | sum[ACC_W];

    // Next-state for every pipe stage, the running partial and the result slot.
    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        v1_d   = v1_q;
        l1_d   = l1_q;
        p_d    = p_q;
        v2_d   = v2_q;
        l2_d   = l2_q;
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        osum_d = osum_q;
        ocnt_d = ocnt_q;
        oovf_d = oovf_q;
        ovld_d = ovld_q;
        if (en) begin
            a_d    = in_a;
            b_d    = in_b;
            v1_d   = in_valid;
            l1_d   = in_last;
            p_d    = prod;
            v2_d   = v1_q;
            l2_d   = l1_q;
            // en implies the slot is empty or being accepted this edge.
            ovld_d = 1'b0;
            if (v2_q) begin
                if (l2_q) begin
                    osum_d = sum[ACC_W-1:0];
                    ocnt_d = cnt_inc;
                    oovf_d = ovf_new;
                    ovld_d = 1'b1;
                    acc_d  = '0;
                    cnt_d  = '0;
                    ovf_d  = 1'b0;
                end else begin
                    acc_d  = sum[ACC_W-1:0];
                    cnt_d  = cnt_inc;
                    ovf_d  = ovf_new;
                end
            end
        end
    end

    // State register; reset and soft clear both flush everything.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            a_q    <= '0;
            b_q    <= '0;
            v1_q   <= 1'b0;
            l1_q   <= 1'b0;
            p_q    <= '0;
            v2_q   <= 1'b0;
            l2_q   <= 1'b0;
            acc_q  <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            osum_q <= '0;
            ocnt_q <= '0;
            oovf_q <= 1'b0;
            ovld_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            v1_q   <= v1_d;
            l1_q   <= l1_d;
            p_q    <= p_d;
            v2_q   <= v2_d;
            l2_q   <= l2_d;
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            osum_q <= osum_d;
            ocnt_q <= ocnt_d;
            oovf_q <= oovf_d;
            ovld_q <= ovld_d;
        end
    end

    assign out_valid = ovld_q;
    assign out_sum   = osum_q;
    assign out_count = ocnt_q;
    assign out_ovf   = oovf_q;

endmodule

// File: doc/mac8_accumulator.md
# mac8_accumulator

Streaming multiply-accumulate stage directly downstream of the 8x8 `multiply8` array. It accepts a valid/ready stream of 8-bit operand pairs and registers each pair into `multiply8`. It captures the 16-bit product and accumulates products into a dot-product result. When a pair is marked last, it emits the sum, term count and overflow flag on a valid/ready output port. It turns the combinational multiplier into a fully pipelined, back-pressurable datapath stage.

## Interface
- `ACC_W`, default 24: accumulator and result width. Must be at least 16. The default of 24 holds 255 full-scale products without overflow.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `clr` input 1: synchronous soft clear. Same effect as reset, held for that cycle.
- `in_valid` input 1: operand pair valid.
- `in_ready` output 1: stage can accept a pair.
- `in_a` input 8: multiplicand, unsigned.
- `in_b` input 8: multiplier, unsigned.
- `in_last` input 1: pair is the final term of the current dot product.
- `out_valid` output 1: result held on the output port.
- `out_ready` input 1: consumer accepts the result.
- `out_sum` output ACC_W: accumulated sum, modulo 2^ACC_W.
- `out_count` output 8: number of terms in the result, saturating at 255.
- `out_ovf` output 1: sticky flag. Set if any accumulation in this result carried out of ACC_W.

## Operation
- Stall enable: `en = !(out_valid && !out_ready) && !clr`.
  - `in_ready = en`.
  - Every pipeline register updates only when `en` is high.
- S1 (operand register): on `en`, loads `a_q`, `b_q`, `v1 = in_valid`, `l1 = in_last`.
- S2 (product register): `multiply8` is driven by `a_q`/`b_q`. On `en`, loads `p_q` (16 bits), `v2 = v1`, `l2 = l1`.
- S3 (accumulate), on `en && v2`:
  - `sum = acc + zero-extended p_q`, computed at ACC_W+1 bits.
  - `acc`, `cnt` and `ovf` hold the running partial.
  - The count increments and saturates at 255.
  - The overflow flag ORs in bit ACC_W of the sum.
  - If `l2` is set:
    - `out_sum`, `out_count` and `out_ovf` load the new totals.
    - `out_valid` is set.
    - `acc`, `cnt` and `ovf` return to 0.
  - Otherwise the running partial is updated in place.
- Output release: `out_valid` clears on `out_ready` when no new last term completes in the same cycle.
- Last term while a result is being accepted: if `out_valid && out_ready` and a last term completes in the same cycle, the output registers take the new result and `out_valid` stays 1.
- Bubbles (`v = 0`) pass through without touching the accumulator.
- `in_a`, `in_b` and `in_last` are ignored when `in_valid` is 0.
- Wrap-around: the sum wraps modulo 2^ACC_W; only `out_ovf` records it.
- A running partial persists indefinitely until its last term arrives. There is no timeout.

## Timing
- Reset and `clr` values: all valid bits, `acc`, `cnt`, `ovf` and `out_*` registers are 0. `in_ready` is therefore 1 on the cycle after reset deasserts.
- Reset or `clr` mid-operation discards in-flight pairs, the partial sum and any unaccepted result.
- Handshake:
  - A pair transfers at an edge where `in_valid && in_ready`.
  - A result transfers at an edge where `out_valid && out_ready`.
  - `out_*` are stable while `out_valid && !out_ready`.
- Latency: a last pair transferred at edge N gives `out_valid = 1` after edge N+2.
- Throughput: one pair per cycle while `out_ready` is high or no result is held.
- Back-to-back last pairs with `out_ready = 1` produce one result per cycle.
- Backpressure: while a held result is unaccepted, the whole pipe freezes and `in_ready = 0`.
- Outputs are registered only. `in_ready` is combinational from `out_valid`, `out_ready` and `clr`.

## Structure
- Shared package `mac_pkg`:
  - Constants `OP_W = 8`, `PROD_W = 16`, `CNT_W = 8`, `CNT_MAX = 255`.
  - Default `ACC_W = 24`.
- One sub-module instance: `multiply8` (existing, combinational; its `clk` pin is tied to `clk`).
- Everything else is flat in `mac8_accumulator`: pipe registers, accumulator and output register.

## Test plan
- Single pair: reset, then send a=255, b=255, last=1 with `out_ready = 1`. Result: `out_valid` rises 2 edges after the transfer, `out_sum = 65025`, `out_count = 1`, `out_ovf = 0`.
- Dot product: send (1,2), (3,4), (5,6), (7,8) consecutively, last on the fourth. Result: `out_sum = 100`, `out_count = 4`, `out_ovf = 0`. `in_ready` stays 1 throughout.
- Backpressure: send (2,3) last and (4,5) last back-to-back with `out_ready = 0`.
  - First result `out_sum = 6` is held and stable.
  - `in_ready` drops and the pipe freezes.
  - Raise `out_ready` for 1 cycle: `out_sum = 20` appears next with `out_count = 1`.
- Overflow with ACC_W=17: send three pairs of (255,255), last on the third. Result: `out_sum = 64003`, `out_count = 3`, `out_ovf = 1`. The next result, (1,1) last, gives `out_ovf = 0`.
- Bubbles: send (10,10), one idle cycle, then (10,10) last. Result: `out_sum = 200`, `out_count = 2`.
- Reset and `clr` mid-operation:
  - Send (9,9) and (8,8) without last, then pulse `rst_n = 0` for one cycle (repeat the run with `clr = 1`).
  - Then send (1,1) last: `out_sum = 1`, `out_count = 1`.
  - During the pulse, `in_ready = 0` for `clr`. For reset, all outputs read 0 after the edge.
